alu_muldiv: RTL

Parametrised execute unit that supersedes the single-cycle combinational ALU. It implements the RV32I integer ops plus the RV32M multiply and divide ops behind a valid/ready handshake. Base ops complete in 1 cycle; multiply and divide run iteratively over XLEN cycles. It sits in the EX stage; the hazard unit stalls the pipeline while `in_ready` is low.

---
 rtl/alu_muldiv.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: RV32I base ops plus RV32M multiply/divide, one request at a time.
// Latency: base ops, opcodes 18-31 and the divide fast paths take 1 cycle; other mul/div ops take XLEN+1 cycles.
// Backpressure: the result is held while out_ready is low; in_ready is low while busy or while a result is held.
// Ports: clk, rst (synchronous, active high);
//        request  : in_valid, in_ready, opcode[4:0], a, b
//        response : out_valid, out_ready, result, zero_flag (result == 0); busy = iterative op running
module alu_muldiv #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      opcode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;

  // Iteration registers. For multiply {acc, mq} is the running product with
  // the multiplier shifting out of mq; for divide acc is the partial remainder
  // and mq shifts the dividend out while quotient bits shift in.
  logic [XLEN-1:0] acc, mq, mcand;
  logic [CW-1:0]   cnt;
  logic [4:0]      op_q;
  logic            neg_q;   // negate product / quotient at the end
  logic            neg_r;   // negate remainder (dividend was negative)
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  // ---------------------------------------------------------------------
  // Issue-side decode and single-cycle results
  // ---------------------------------------------------------------------
  logic [SHW-1:0]  shamt;
  logic            is_mul, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, goes_busy, accept;
  logic [XLEN-1:0] base_res, issue_res;

  assign shamt  = b[SHW-1:0];
  assign is_mul = (opcode >= OP_MUL) && (opcode <= OP_MULHU);
  assign is_div = (opcode >= OP_DIV) && (opcode <= OP_REMU);
  assign a_sgn  = (opcode == OP_MULH) || (opcode == OP_MULHSU) ||
                  (opcode == OP_DIV)  || (opcode == OP_REM);
  assign b_sgn  = (opcode == OP_MULH) || (opcode == OP_DIV) || (opcode == OP_REM);
  assign a_neg  = a_sgn & a[XLEN-1];
  assign b_neg  = b_sgn & b[XLEN-1];
  assign a_mag  = a_neg ? (~a + 1'b1) : a;
  assign b_mag  = b_neg ? (~b + 1'b1) : b;

  assign div_zero  = is_div && (b == '0);
  assign div_ovf   = ((opcode == OP_DIV) || (opcode == OP_REM)) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign goes_busy = is_mul || (is_div && !div_zero && !div_ovf);

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    base_res = '0;
    case (opcode)
      OP_ADD:  base_res = a + b;
      OP_SUB:  base_res = a - b;
      OP_SLL:  base_res = a << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:  base_res = a ^ b;
      OP_SRL:  base_res = a >> shamt;
      OP_SRA:  base_res = $signed(a) >>> shamt;
      OP_OR:   base_res = a | b;
      OP_AND:  base_res = a & b;
      default: base_res = '0;
    endcase
  end

  // Divide corner cases resolve at issue and never enter the iteration.
  always_comb begin
    issue_res = base_res;
    if (div_zero) begin
      issue_res = ((opcode == OP_DIV) || (opcode == OP_DIVU)) ? '1 : a;
    end else if (div_ovf) begin
      issue_res = (opcode == OP_DIV) ? a : '0;
    end
  end

  // ---------------------------------------------------------------------
  // One iteration step (shift-add multiply / restoring divide)
  // ---------------------------------------------------------------------
  logic            op_q_mul;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] acc_nx, mq_nx;

  assign op_q_mul  = (op_q < OP_DIV);
  assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
  assign div_shift = {acc, mq[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, mcand};
  // The partial remainder stays below the divisor, so a borrow into the top
  // bit of the difference means the trial subtraction failed.
  assign div_ge    = ~div_diff[XLEN];

  always_comb begin
    acc_nx = acc;
    mq_nx  = mq;
    if (op_q_mul) begin
      acc_nx = mul_sum[XLEN:1];
      mq_nx  = {mul_sum[0], mq[XLEN-1:1]};
    end else begin
      acc_nx = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      mq_nx  = {mq[XLEN-2:0], div_ge};
    end
  end

  // Sign fix-up and result select for the final step.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  assign prod = neg_q ? (~{acc_nx, mq_nx} + 1'b1) : {acc_nx, mq_nx};
  assign quo  = neg_q ? (~mq_nx + 1'b1) : mq_nx;
  assign rem  = neg_r ? (~acc_nx + 1'b1) : acc_nx;

  always_comb begin
    final_res = rem;
    case (op_q)
      OP_MUL:                       final_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_res = quo;
      default:                      final_res = rem;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = goes_busy ? BUSY : DONE;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (accept) begin
            state_nx = goes_busy ? BUSY : DONE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      mq       <= '0;
      mcand    <= '0;
      cnt      <= '0;
      op_q     <= OP_ADD;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept) begin
      op_q <= opcode;
      if (goes_busy) begin
        acc   <= '0;
        mq    <= a_mag;
        mcand <= b_mag;
        cnt   <= CW'(XLEN);
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
      end else begin
        result_q <= issue_res;
        zero_q   <= (issue_res == '0);
      end
    end else if (state == BUSY) begin
      acc <= acc_nx;
      mq  <= mq_nx;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        result_q <= final_res;
        zero_q   <= (final_res == '0);
      end
    end
  end

  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule
